// File: rtl/pb_keypad_pkg.sv
// Shared register offsets, STATUS bit positions and snapshot helpers for the
// pb_keypad peripheral and its keypad_scan sub-module.
package pb_keypad_pkg;

    localparam logic [7:0] KP_STATUS  = 8'd0;
    localparam logic [7:0] KP_KEY     = 8'd1;
    localparam logic [7:0] KP_CONTROL = 8'd2;

    localparam int ST_KEY_VALID = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_KEY_HELD  = 2;
    localparam int ST_FILL_LO   = 4;

    localparam logic [1:0] CONTROL_RESET = 2'b01;

    typedef enum logic [1:0] {
        SNAP_NONE,
        SNAP_SINGLE,
        SNAP_MULTI
    } snap_kind_t;

    function automatic snap_kind_t classify(input logic [15:0] snap);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(snap[i]);
        end
        if (n == 5'd0) begin
            return SNAP_NONE;
        end else if (n == 5'd1) begin
            return SNAP_SINGLE;
        end
        return SNAP_MULTI;
    endfunction

    // Bit index r*4+c of the snapshot is already the key code.
    function automatic logic [3:0] encode_key(input logic [15:0] snap);
        logic [3:0] code;
        code = '0;
        for (int i = 15; i >= 0; i--) begin
            if (snap[i]) begin
                code = 4'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/pb_keypad_scan.sv
// keypad_scan: column drive, row synchronizer, dwell counter, full-sweep
// snapshot and debounce; emits a one-clock key_stb with the key code.
module keypad_scan
    import pb_keypad_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter logic [3:0]  DEBOUNCE = 4'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_en,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_stb,
    output logic [3:0] keycode,
    output logic       key_held
);

    logic [3:0]  row_meta;
    logic [3:0]  row_sync;
    logic        active;
    logic [1:0]  col_idx;
    logic [15:0] dwell;
    logic [15:0] snap_work;
    logic [15:0] snap_prev;
    logic [15:0] snap_full;
    logic [3:0]  stable_cnt;
    logic        col_done;
    logic        sweep_done;
    logic        accept;
    snap_kind_t  kind;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // active lags scan_en by a clock so col stays parked out of reset.
    assign col = active ? ~(4'b0001 << col_idx) : 4'hF;

    always_comb begin
        logic [3:0] idx;
        col_done   = active && (dwell == SCAN_DIV - 16'd1);
        sweep_done = col_done && (col_idx == 2'd3);
        snap_full  = snap_work;
        for (int r = 0; r < 4; r++) begin
            idx            = {2'(r), col_idx};
            snap_full[idx] = ~row_sync[r];
        end
        kind   = classify(snap_full);
        accept = sweep_done && (snap_full == snap_prev)
                 && (stable_cnt == DEBOUNCE - 4'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active     <= 1'b0;
            col_idx    <= '0;
            dwell      <= '0;
            snap_work  <= '0;
            snap_prev  <= '0;
            stable_cnt <= '0;
            key_stb    <= 1'b0;
            keycode    <= '0;
            key_held   <= 1'b0;
        end else if (!scan_en) begin
            active     <= 1'b0;
            col_idx    <= '0;
            dwell      <= '0;
            snap_work  <= '0;
            snap_prev  <= '0;
            stable_cnt <= '0;
            key_stb    <= 1'b0;
        end else begin
            active  <= 1'b1;
            key_stb <= 1'b0;
            if (active) begin
                if (col_done) begin
                    dwell     <= '0;
                    col_idx   <= col_idx + 2'd1;
                    snap_work <= snap_full;
                    if (sweep_done) begin
                        snap_prev <= snap_full;
                        if (snap_full != snap_prev) begin
                            stable_cnt <= '0;
                        end else if (stable_cnt != DEBOUNCE) begin
                            stable_cnt <= stable_cnt + 4'd1;
                        end
                    end
                end else begin
                    dwell <= dwell + 16'd1;
                end
            end
            // Ghosted or multi-key snapshots leave key_held untouched.
            if (accept) begin
                case (kind)
                    SNAP_SINGLE: begin
                        if (!key_held) begin
                            key_stb  <= 1'b1;
                            keycode  <= encode_key(snap_full);
                            key_held <= 1'b1;
                        end
                    end
                    SNAP_NONE: key_held <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/pb_keypad.sv
// PicoBlaze 4x4 keypad input peripheral: register decode, key holding
// register (or 4-deep FIFO when KEYPAD_FIFO_EN is defined) and interrupt.
module pb_keypad
    import pb_keypad_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDRESS = 8'h00,
    parameter logic [15:0] SCAN_DIV     = 16'd50000,
    parameter logic [3:0]  DEBOUNCE     = 4'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       read_strobe,
    input  logic       write_strobe,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic       interrupt
);

    logic [7:0] offset;
    logic [1:0] control;
    logic       scan_stb;
    logic [3:0] scan_code;
    logic       key_held;
    logic       key_valid;
    logic       key_valid_next;
    logic       overrun;
    logic [3:0] key_head;
    logic [1:0] fill_field;
    logic       pop;
    logic       clr_ovr;
    logic [7:0] status_word;
    logic       unused_data;

    assign offset      = port_id - BASE_ADDRESS;
    assign pop         = read_strobe && (offset == KP_KEY);
    assign clr_ovr     = write_strobe && (offset == KP_STATUS) && data_in[ST_OVERRUN];
    assign unused_data = ^data_in[7:2];

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .scan_en  (control[0]),
        .row      (row),
        .col      (col),
        .key_stb  (scan_stb),
        .keycode  (scan_code),
        .key_held (key_held)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            control <= CONTROL_RESET;
        end else if (write_strobe && (offset == KP_CONTROL)) begin
            control <= data_in[1:0];
        end
    end

`ifdef KEYPAD_FIFO_EN
    logic [3:0] fifo_mem [0:3];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic [2:0] count_next;
    logic       pop_ok;
    logic       push_ok;

    // A pop in the same clock frees the slot a full-FIFO push needs.
    always_comb begin
        pop_ok         = pop && (count != 3'd0);
        push_ok        = scan_stb && ((count != 3'd4) || pop_ok);
        count_next     = count + {2'b0, push_ok} - {2'b0, pop_ok};
        key_valid_next = (count_next != 3'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= scan_code;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count_next;
            if (scan_stb && !push_ok) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign key_valid  = (count != 3'd0);
    assign key_head   = fifo_mem[rd_ptr];
    assign fill_field = key_valid ? 2'(count - 3'd1) : 2'd0;
`else
    logic [3:0] key_reg;
    logic       load;

    always_comb begin
        load           = scan_stb && (!key_valid || pop);
        key_valid_next = key_valid;
        if (load) begin
            key_valid_next = 1'b1;
        end else if (pop) begin
            key_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_reg   <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            key_valid <= key_valid_next;
            if (load) begin
                key_reg <= scan_code;
            end
            if (scan_stb && !load) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign key_head   = key_reg;
    assign fill_field = 2'd0;
`endif

    always_comb begin
        status_word                = '0;
        status_word[ST_KEY_VALID]  = key_valid;
        status_word[ST_OVERRUN]    = overrun;
        status_word[ST_KEY_HELD]   = key_held;
        status_word[ST_FILL_LO+:2] = fill_field;
    end

    // Registered read mux; undecoded addresses return 0 for OR-combining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            interrupt <= 1'b0;
        end else begin
            interrupt <= control[1] && key_valid_next;
            case (offset)
                KP_STATUS:  data_out <= status_word;
                KP_KEY:     data_out <= {4'b0, key_head};
                KP_CONTROL: data_out <= {6'b0, control};
                default:    data_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pb_keypad.sv
// Self-checking bench for pb_keypad with SCAN_DIV=4, DEBOUNCE=2; a matrix
// model drives row from col and a scoreboard tracks expected key codes.
`timescale 1ns/1ps
module tb_pb_keypad;

    localparam logic [7:0]  BASE     = 8'h00;
    localparam logic [15:0] SCAN_DIV = 16'd4;
    localparam logic [3:0]  DEBOUNCE = 4'd2;
    localparam int          SWEEP    = 16;
    localparam int          SETTLE   = 6 * SWEEP;
    localparam logic [7:0]  A_STATUS = BASE + 8'd0;
    localparam logic [7:0]  A_KEY    = BASE + 8'd1;
    localparam logic [7:0]  A_CTRL   = BASE + 8'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] port_id = '0;
    logic [7:0] data_in = '0;
    logic       read_strobe = 1'b0;
    logic       write_strobe = 1'b0;
    logic [7:0] data_out;
    logic [3:0] col;
    logic [3:0] row;
    logic       interrupt;
    logic [15:0] keys = '0;

    int checks = 0;
    int errors = 0;
    int stb_count = 0;
    logic [3:0] sb_q[$];

    pb_keypad #(
        .BASE_ADDRESS (BASE),
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE     (DEBOUNCE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .data_in      (data_in),
        .data_out     (data_out),
        .read_strobe  (read_strobe),
        .write_strobe (write_strobe),
        .col          (col),
        .row          (row),
        .interrupt    (interrupt)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(keys[r*4 +: 4] & ~col);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] pattern, input int cycles);
        keys = pattern;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [7:0] addr, input logic [7:0] data);
        @(posedge clk);
        #1;
        port_id      = addr;
        data_in      = data;
        write_strobe = 1'b1;
        @(posedge clk);
        #1;
        write_strobe = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [7:0] addr,
                             input logic [7:0] expected);
        @(posedge clk);
        #1;
        port_id     = addr;
        read_strobe = 1'b1;
        @(posedge clk);
        #1;
        read_strobe = 1'b0;
        checkOutput(tag, 32'(data_out), 32'(expected));
    endtask

    task automatic waitInterrupt(input string tag, input int budget);
        int n;
        n = 0;
        while (interrupt !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, 32'(interrupt), 32'd1);
    endtask

    // Scoreboard: every key strobe must match the oldest expected code.
    always @(negedge clk) begin
        if (!reset && dut.u_scan.key_stb) begin
            stb_count++;
            checkOutput("stb_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                checkOutput("stb_keycode", 32'(dut.u_scan.keycode), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wait_cnt;
        int stb_before;
        logic [3:0] exp_col;

        // Reset state and idle column sequence
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_col", 32'(col), 32'hF);
        checkOutput("reset_data_out", 32'(data_out), 32'h0);
        checkOutput("reset_interrupt", 32'(interrupt), 32'h0);
        reset = 1'b0;
        wait_cnt = 0;
        while (col == 4'hF && wait_cnt < 20) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        checkOutput("scan_start", 32'(col != 4'hF), 32'd1);
        for (int k = 0; k < 32; k++) begin
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            checkOutput("col_seq", 32'(col), 32'(exp_col));
            @(posedge clk);
            #1;
        end
        readCheck("idle_status", A_STATUS, 8'h00);
        readCheck("idle_control", A_CTRL, 8'h01);

        // Single key (2,1)
        sb_q.push_back(4'd9);
        applyStimulus(16'h0200, SETTLE);
        readCheck("k9_status", A_STATUS, 8'h05);
        readCheck("k9_key", A_KEY, 8'h09);
        readCheck("k9_status_after_pop", A_STATUS, 8'h04);
        applyStimulus(16'h0000, SETTLE);
        readCheck("k9_released", A_STATUS, 8'h00);

        // Bouncing key (0,3) then stable
        sb_q.push_back(4'd3);
        stb_before = stb_count;
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i % 2 == 0) ? 16'h0008 : 16'h0000, SWEEP);
        end
        applyStimulus(16'h0008, SETTLE);
        checkOutput("bounce_stb_count", 32'(stb_count - stb_before), 32'd1);
        readCheck("k3_key", A_KEY, 8'h03);
        applyStimulus(16'h0000, SETTLE);

        // Two keys without reading in between
        sb_q.push_back(4'd5);
        applyStimulus(16'h0020, SETTLE);
        applyStimulus(16'h0000, SETTLE);
        sb_q.push_back(4'd6);
        applyStimulus(16'h0040, SETTLE);
        applyStimulus(16'h0000, SETTLE);
`ifdef KEYPAD_FIFO_EN
        readCheck("two_status", A_STATUS, 8'h11);
        busWrite(A_STATUS, 8'h02);
        readCheck("two_status_clr", A_STATUS, 8'h11);
        readCheck("two_key_first", A_KEY, 8'h05);
        readCheck("two_status_one_left", A_STATUS, 8'h01);
        readCheck("two_key_second", A_KEY, 8'h06);
        readCheck("two_status_empty", A_STATUS, 8'h00);
`else
        readCheck("ovr_status", A_STATUS, 8'h03);
        busWrite(A_STATUS, 8'h02);
        readCheck("ovr_status_clr", A_STATUS, 8'h01);
        readCheck("ovr_key", A_KEY, 8'h05);
        readCheck("ovr_status_empty", A_STATUS, 8'h00);
`endif

        // Interrupt rise and fall
        busWrite(A_CTRL, 8'h03);
        readCheck("ctrl_int_en", A_CTRL, 8'h03);
        sb_q.push_back(4'd0);
        keys = 16'h0001;
        waitInterrupt("int_rise", 200);
        readCheck("int_status", A_STATUS, 8'h05);
        checkOutput("int_still_high", 32'(interrupt), 32'd1);
        readCheck("int_key", A_KEY, 8'h00);
        checkOutput("int_fall", 32'(interrupt), 32'd0);
        applyStimulus(16'h0000, SETTLE);

        // Multi-key press is rejected
        stb_before = stb_count;
        applyStimulus(16'h0420, SETTLE);
        checkOutput("multi_no_stb", 32'(stb_count - stb_before), 32'd0);
        readCheck("multi_status", A_STATUS, 8'h00);
        applyStimulus(16'h0000, SETTLE);

        // Disable scanning mid-sweep
        repeat (6) @(posedge clk);
        #1;
        busWrite(A_CTRL, 8'h00);
        @(posedge clk);
        #1;
        checkOutput("col_parked", 32'(col), 32'hF);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("col_stays_parked", 32'(col), 32'hF);
        readCheck("ctrl_off", A_CTRL, 8'h00);

        // Asynchronous reset mid-dwell with a key pending
        busWrite(A_CTRL, 8'h03);
        sb_q.push_back(4'd15);
        keys = 16'h8000;
        waitInterrupt("pre_reset_int", 200);
        port_id = A_CTRL;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pre_reset_data_out", 32'(data_out), 32'h03);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midreset_col", 32'(col), 32'hF);
        checkOutput("midreset_data_out", 32'(data_out), 32'h0);
        checkOutput("midreset_interrupt", 32'(interrupt), 32'h0);
        keys = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        readCheck("post_reset_control", A_CTRL, 8'h01);
        readCheck("post_reset_status", A_STATUS, 8'h00);

        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
